// File: rtl/ast_pkg.sv
// Shared constants and FSM encoding for the systolic-row result path.
// Imported by the drain unit and by the array top / MAC PE instantiation.
package ast_pkg;

    localparam int AST_DATAWIDTH = 16;
    localparam int AST_NUM_PE    = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } ast_state_e;

endpackage

// File: rtl/ast_drain_v.sv
// Result-drain unit: snapshots NUM_PE accumulators on capture and serializes
// them one word per valid/ready handshake, so the array can restart at once.
module ast_drain_v
    import ast_pkg::*;
#(
    parameter int DATAWIDTH = AST_DATAWIDTH,
    parameter int ACCWIDTH  = 2*DATAWIDTH,
    parameter int NUM_PE    = AST_NUM_PE,
    parameter int IDXWIDTH  = $clog2(NUM_PE)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_PE*ACCWIDTH-1:0] acc_in,
    input  logic                       capture,
    output logic                       capture_ack,
    output logic [ACCWIDTH-1:0]        out_data,
    output logic [IDXWIDTH-1:0]        out_index,
    output logic                       out_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       overrun
);

    ast_state_e          r_state;
    logic [ACCWIDTH-1:0] r_buf [NUM_PE];
    logic [IDXWIDTH-1:0] r_idx;
    logic                r_ack;
    logic                r_overrun;

    logic w_drain;
    logic w_last_idx;
    logic w_xfer;
    logic w_final_xfer;

    assign w_drain      = (r_state == ST_DRAIN);
    assign w_last_idx   = (r_idx == IDXWIDTH'(NUM_PE-1));
    assign w_xfer       = w_drain && out_ready;
    assign w_final_xfer = w_xfer && w_last_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_ack     <= 1'b0;
            r_overrun <= 1'b0;
            for (int k = 0; k < NUM_PE; k++) begin
                r_buf[k] <= '0;
            end
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (capture) begin
                        for (int k = 0; k < NUM_PE; k++) begin
                            r_buf[k] <= acc_in[k*ACCWIDTH +: ACCWIDTH];
                        end
                        r_idx   <= '0;
                        r_ack   <= 1'b1;
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // A capture coinciding with the final beat reloads without a bubble.
                    if (w_final_xfer) begin
                        r_idx <= '0;
                        if (capture) begin
                            for (int k = 0; k < NUM_PE; k++) begin
                                r_buf[k] <= acc_in[k*ACCWIDTH +: ACCWIDTH];
                            end
                            r_ack <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        if (w_xfer) begin
                            r_idx <= r_idx + IDXWIDTH'(1);
                        end
                        if (capture) begin
                            r_overrun <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    assign out_valid   = w_drain;
    assign busy        = w_drain;
    assign out_data    = r_buf[r_idx];
    assign out_index   = r_idx;
    assign out_last    = w_drain && w_last_idx;
    assign capture_ack = r_ack;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_ast_drain_v.sv
// Scoreboard bench for ast_drain_v: stimulus pushes expected beats, a monitor
// pops and compares on every accepted transfer.
module tb_ast_drain_v;

    localparam int AW = 32;
    localparam int NP = 4;
    localparam int IW = 2;

    typedef struct {
        logic [AW-1:0] d;
        logic [IW-1:0] i;
        logic          l;
    } exp_t;

    logic              clk;
    logic              reset;
    logic [NP*AW-1:0]  acc_in;
    logic              capture;
    logic              capture_ack;
    logic [AW-1:0]     out_data;
    logic [IW-1:0]     out_index;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              overrun;

    exp_t          q[$];
    int            n_checks;
    int            n_errors;
    int            acks_seen;
    int            acks_exp;
    logic          stall_prev;
    logic [AW-1:0] hold_d;
    logic [IW-1:0] hold_i;

    ast_drain_v dut (
        .clk         (clk),
        .reset       (reset),
        .acc_in      (acc_in),
        .capture     (capture),
        .capture_ack (capture_ack),
        .out_data    (out_data),
        .out_index   (out_index),
        .out_last    (out_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push4(input logic [AW-1:0] w0, input logic [AW-1:0] w1,
                         input logic [AW-1:0] w2, input logic [AW-1:0] w3);
        logic [AW-1:0] w [NP];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        for (int k = 0; k < NP; k++) begin
            q.push_back('{d: w[k], i: IW'(k), l: (k == NP-1)});
        end
    endtask

    // Drive a capture that the DUT is expected to accept.
    task automatic do_capture(input logic [AW-1:0] w0, input logic [AW-1:0] w1,
                              input logic [AW-1:0] w2, input logic [AW-1:0] w3);
        acc_in  = {w3, w2, w1, w0};
        capture = 1'b1;
        push4(w0, w1, w2, w3);
        acks_exp++;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (stall_prev) begin
                check("hold_data", 64'(out_data), 64'(hold_d));
                check("hold_index", 64'(out_index), 64'(hold_i));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_beat", 64'(out_index), 64'hFFFF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("beat_data", 64'(out_data), 64'(e.d));
                    check("beat_index", 64'(out_index), 64'(e.i));
                    check("beat_last", 64'(out_last), 64'(e.l));
                end
            end
            if (capture_ack) acks_seen++;
            stall_prev = out_valid && !out_ready;
            hold_d     = out_data;
            hold_i     = out_index;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        logic bp_seq [7];
        n_checks = 0; n_errors = 0; acks_seen = 0; acks_exp = 0;
        stall_prev = 1'b0; hold_d = '0; hold_i = '0;
        reset = 1'b0; capture = 1'b0; out_ready = 1'b0; acc_in = '0;
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_flags", 64'({capture_ack, busy, overrun, out_last, out_index}), 64'd0);
        tick(); tick();
        reset = 1'b1;
        tick();

        // Basic drain with ready held high
        out_ready = 1'b1;
        do_capture(32'h00000011, 32'h00000022, 32'h00000033, 32'hFFFF0044);
        tick();
        capture = 1'b0;
        check("basic_ack", 64'(capture_ack), 64'd1);
        check("basic_valid", 64'(out_valid), 64'd1);
        check("basic_data0", 64'(out_data), 64'h11);
        tick();
        check("basic_ack_once", 64'(capture_ack), 64'd0);
        tick(); tick(); tick();
        check("basic_idle_valid", 64'(out_valid), 64'd0);
        check("basic_idle_busy", 64'(busy), 64'd0);
        check("basic_q_empty", 64'(q.size()), 64'd0);

        // Backpressure
        out_ready = 1'b0;
        do_capture(32'h00000011, 32'h00000022, 32'h00000033, 32'hFFFF0044);
        tick();
        capture = 1'b0;
        bp_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            out_ready = bp_seq[i];
            tick();
        end
        out_ready = 1'b0;
        check("bp_done_valid", 64'(out_valid), 64'd0);
        check("bp_q_empty", 64'(q.size()), 64'd0);

        // Snapshot isolation
        out_ready = 1'b1;
        do_capture(32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004);
        tick();
        capture = 1'b0;
        acc_in  = {NP{32'hDEADBEEF}};
        tick(); tick(); tick(); tick();
        check("iso_q_empty", 64'(q.size()), 64'd0);

        // Back-to-back capture on the final beat
        do_capture(32'h00000011, 32'h00000022, 32'h00000033, 32'hFFFF0044);
        tick();
        capture = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("b2b_valid_hold", 64'(out_valid), 64'd1);
        end
        check("b2b_at_last", 64'(out_last), 64'd1);
        do_capture(32'h1, 32'h2, 32'h3, 32'h4);
        tick();
        capture = 1'b0;
        check("b2b_ack", 64'(capture_ack), 64'd1);
        check("b2b_valid", 64'(out_valid), 64'd1);
        check("b2b_idx0", 64'(out_index), 64'd0);
        check("b2b_data0", 64'(out_data), 64'h1);
        tick(); tick(); tick(); tick();
        check("b2b_idle", 64'(out_valid), 64'd0);
        check("b2b_overrun", 64'(overrun), 64'd0);
        check("b2b_q_empty", 64'(q.size()), 64'd0);

        // Dropped capture during beat 1
        do_capture(32'h00000101, 32'h00000202, 32'h00000303, 32'h00000404);
        tick();
        capture = 1'b0;
        tick();
        check("ovr_idx1", 64'(out_index), 64'd1);
        acc_in  = {NP{32'hDEADBEEF}};
        capture = 1'b1;
        tick();
        capture = 1'b0;
        check("ovr_no_ack", 64'(capture_ack), 64'd0);
        check("ovr_set", 64'(overrun), 64'd1);
        tick(); tick();
        check("ovr_idle", 64'(out_valid), 64'd0);
        check("ovr_sticky_idle", 64'(overrun), 64'd1);
        check("ovr_q_empty", 64'(q.size()), 64'd0);
        do_capture(32'h5, 32'h6, 32'h7, 32'h8);
        tick();
        capture = 1'b0;
        tick(); tick(); tick(); tick();
        check("ovr_sticky_after", 64'(overrun), 64'd1);
        check("ovr2_q_empty", 64'(q.size()), 64'd0);

        // Asynchronous reset during beat 2
        do_capture(32'hC0, 32'hC1, 32'hC2, 32'hC3);
        tick();
        capture = 1'b0;
        tick(); tick();
        check("arst_pre_idx", 64'(out_index), 64'd2);
        #2;
        reset = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_data", 64'(out_data), 64'd0);
        check("arst_flags", 64'({capture_ack, busy, overrun, out_last, out_index}), 64'd0);
        q.delete();
        tick(); tick();
        reset = 1'b1;
        tick();
        do_capture(32'hD0, 32'hD1, 32'hD2, 32'hD3);
        tick();
        capture = 1'b0;
        check("arst_new_idx0", 64'(out_index), 64'd0);
        check("arst_new_data0", 64'(out_data), 64'hD0);
        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        check("arst_q_empty", 64'(q.size()), 64'd0);
        tick();
        check("ack_count", 64'(acks_seen), 64'(acks_exp));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
